// File: rtl/clip_merge.sv
// Merges SEGMENTS consecutive input transactions into one output transaction.
// Data passes through combinationally; each suppressed eot reports its segment length on cnt.
module clip_merge #(
  parameter int SEGMENTS = 2,
  parameter int CNT_W    = 16,
  parameter int W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [W:0]       din_data,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [W:0]       dout_data,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic [CNT_W-1:0] cnt_data
);

  localparam int SEG_W = $clog2(SEGMENTS);
  localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(SEGMENTS - 1);

  logic [SEG_W-1:0] seg_r;
  logic [CNT_W-1:0] len_r;
  logic [CNT_W-1:0] cnt_data_r;
  logic             cnt_valid_r;

  logic             din_eot_s;
  logic             last_seg_s;
  logic             boundary_s;
  logic             stall_s;
  logic             hs_s;
  logic             push_s;
  logic             pop_s;
  logic [CNT_W-1:0] len_inc_s;

  // Length counters hold at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  // Handshake, stall and eot-suppression logic.
  always_comb begin
    din_eot_s  = din_data[W];
    last_seg_s = (seg_r == LAST_SEG);
    boundary_s = din_valid & din_eot_s & ~last_seg_s;
    // A boundary item may only pass when the report buffer has room or drains now.
    stall_s    = boundary_s & cnt_valid_r & ~cnt_ready;
    dout_valid = din_valid & ~stall_s;
    din_ready  = dout_ready & ~stall_s;
    hs_s       = din_valid & din_ready;
    push_s     = hs_s & boundary_s;
    pop_s      = cnt_valid_r & cnt_ready;
    dout_data  = {din_eot_s & last_seg_s, din_data[W-1:0]};
    len_inc_s  = sat_inc(len_r);
  end

  assign cnt_valid = cnt_valid_r;
  assign cnt_data  = cnt_data_r;

  // Segment index, running length and one-deep report buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r       <= '0;
      len_r       <= '0;
      cnt_data_r  <= '0;
      cnt_valid_r <= 1'b0;
    end else begin
      if (hs_s) begin
        if (!din_eot_s) begin
          len_r <= len_inc_s;
        end else if (last_seg_s) begin
          seg_r <= '0;
          len_r <= '0;
        end else begin
          seg_r <= seg_r + SEG_W'(1);
          len_r <= '0;
        end
      end
      // A push wins over a pop, so pop-and-push keeps valid high with the new value.
      if (push_s) begin
        cnt_data_r  <= len_inc_s;
        cnt_valid_r <= 1'b1;
      end else if (pop_s) begin
        cnt_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clip_merge.sv
// Bench for clip_merge: three instances (SEGMENTS=2, SEGMENTS=3, CNT_W=3) checked
// every cycle against a transaction-level model plus hand-computed report values.
module tb_clip_merge;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        din_valid [N];
  logic        din_ready [N];
  logic [8:0]  din_data  [N];
  logic        dout_valid[N];
  logic        dout_ready[N];
  logic [8:0]  dout_data [N];
  logic        cnt_valid [N];
  logic        cnt_ready [N];
  logic [15:0] cnt_data  [N];
  logic [2:0]  cnt_data_c;

  int segs[N] = '{2, 3, 2};
  int cmax[N] = '{65535, 65535, 7};

  // expected dout items / expected reports, written by stimulus, consumed by the model
  logic [8:0] eo[N][256];
  int eo_w[N] = '{0, 0, 0};
  int eo_r[N] = '{0, 0, 0};
  int ec[N][64];
  int ec_w[N] = '{0, 0, 0};
  int ec_r[N] = '{0, 0, 0};
  // reports observed on cnt, in order
  int lg[N][16];
  int lg_n[N] = '{0, 0, 0};
  // model state: transaction-relative segment number and reports held in the buffer
  int seg_m[N]   = '{0, 0, 0};
  int outst_m[N] = '{0, 0, 0};

  int n_cmp = 0;
  int n_bad = 0;

  clip_merge #(.SEGMENTS(2), .CNT_W(16), .W(8)) u0 (
    .clk(clk), .rst(rst),
    .din_valid(din_valid[0]), .din_ready(din_ready[0]), .din_data(din_data[0]),
    .dout_valid(dout_valid[0]), .dout_ready(dout_ready[0]), .dout_data(dout_data[0]),
    .cnt_valid(cnt_valid[0]), .cnt_ready(cnt_ready[0]), .cnt_data(cnt_data[0]));

  clip_merge #(.SEGMENTS(3), .CNT_W(16), .W(8)) u1 (
    .clk(clk), .rst(rst),
    .din_valid(din_valid[1]), .din_ready(din_ready[1]), .din_data(din_data[1]),
    .dout_valid(dout_valid[1]), .dout_ready(dout_ready[1]), .dout_data(dout_data[1]),
    .cnt_valid(cnt_valid[1]), .cnt_ready(cnt_ready[1]), .cnt_data(cnt_data[1]));

  clip_merge #(.SEGMENTS(2), .CNT_W(3), .W(8)) u2 (
    .clk(clk), .rst(rst),
    .din_valid(din_valid[2]), .din_ready(din_ready[2]), .din_data(din_data[2]),
    .dout_valid(dout_valid[2]), .dout_ready(dout_ready[2]), .dout_data(dout_data[2]),
    .cnt_valid(cnt_valid[2]), .cnt_ready(cnt_ready[2]), .cnt_data(cnt_data_c));

  assign cnt_data[2] = {13'd0, cnt_data_c};

  task automatic chk(string nm, int k, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[%0d] @%0t: got %0d expected %0d", nm, k, $time, act, exp);
    end
  endtask

  // an eot that closes a non-final segment while the report buffer is full and not draining
  function automatic logic stall_f(int k);
    return din_valid[k] && din_data[k][8] && (seg_m[k] != segs[k] - 1) &&
           (outst_m[k] > 0) && !cnt_ready[k];
  endfunction

  function automatic logic push_f(int k);
    return din_valid[k] && dout_ready[k] && !stall_f(k) && din_data[k][8] &&
           (seg_m[k] != segs[k] - 1);
  endfunction

  // compare process: every cycle, away from the clock edge
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        chk("dout_valid", k, dout_valid[k], din_valid[k] && !stall_f(k));
        chk("din_ready", k, din_ready[k], dout_ready[k] && !stall_f(k));
        chk("cnt_valid", k, cnt_valid[k], outst_m[k] > 0);
        if (din_valid[k] && !stall_f(k)) begin
          if (eo_r[k] >= eo_w[k]) chk("dout_extra", k, 1, 0);
          else chk("dout_data", k, dout_data[k], eo[k][eo_r[k]]);
        end
        if (outst_m[k] > 0) begin
          if (ec_r[k] >= ec_w[k]) chk("cnt_extra", k, 1, 0);
          else chk("cnt_data", k, cnt_data[k], ec[k][ec_r[k]]);
          if (cnt_ready[k] && lg_n[k] < 16) begin
            lg[k][lg_n[k]] <= int'(cnt_data[k]);
            lg_n[k] <= lg_n[k] + 1;
          end
        end
      end
    end
  end

  // model update on the clock edge (inputs change only #1 after it)
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        seg_m[k]   <= 0;
        outst_m[k] <= 0;
        eo_r[k]    <= eo_w[k];
        ec_r[k]    <= ec_w[k];
      end else begin
        if (din_valid[k] && dout_ready[k] && !stall_f(k)) begin
          eo_r[k] <= eo_r[k] + 1;
          if (din_data[k][8]) seg_m[k] <= (seg_m[k] == segs[k] - 1) ? 0 : seg_m[k] + 1;
        end
        if (outst_m[k] > 0 && cnt_ready[k]) ec_r[k] <= ec_r[k] + 1;
        outst_m[k] <= outst_m[k] + (push_f(k) ? 1 : 0) - ((outst_m[k] > 0 && cnt_ready[k]) ? 1 : 0);
      end
    end
  end

  // present one item, hold it until accepted (bounded), expected output queued first
  task automatic put(int k, logic [8:0] d, logic exp_eot);
    int n;
    eo[k][eo_w[k]] = {exp_eot, d[7:0]};
    eo_w[k] = eo_w[k] + 1;
    din_valid[k] = 1'b1;
    din_data[k]  = d;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (din_ready[k]) break;
    end
    if (n >= 200) chk("din_timeout", k, 1, 0);
    @(posedge clk);
    #1;
    din_valid[k] = 1'b0;
  endtask

  // one full output transaction made of segs[k] segments of the given lengths
  task automatic txn(int k, int l0, int l1, int l2, int base);
    int L[3];
    L = '{l0, l1, l2};
    for (int s = 0; s < segs[k] - 1; s++) begin
      ec[k][ec_w[k]] = (L[s] > cmax[k]) ? cmax[k] : L[s];
      ec_w[k] = ec_w[k] + 1;
    end
    for (int s = 0; s < segs[k]; s++)
      for (int i = 0; i < L[s]; i++)
        put(k, {(i == L[s] - 1) ? 1'b1 : 1'b0, 8'(base + 16 * s + i)},
            (i == L[s] - 1) && (s == segs[k] - 1));
  endtask

  task automatic chk_log(int k, int idx, int exp);
    chk("cnt_report", k, (idx < lg_n[k]) ? lg[k][idx] : -1, exp);
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit done;
    for (int k = 0; k < N; k++) begin
      din_valid[k]  = 1'b0;
      din_data[k]   = 9'd0;
      dout_ready[k] = 1'b1;
      cnt_ready[k]  = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk("reset_cnt_valid", k, cnt_valid[k], 0);
      chk("reset_dout_valid", k, dout_valid[k], 0);
    end
    idle(1);

    // 1: SEGMENTS=2, [a0 a1 a2] [b0 b1] -> one report of 3
    txn(0, 3, 2, 0, 8'h10);
    idle(4);
    chk_log(0, 0, 3);
    chk("t1_reports", 0, lg_n[0], 1);

    // 2: SEGMENTS=3, lengths 1,4,2 -> reports 1 then 4
    txn(1, 1, 4, 2, 8'h40);
    idle(4);
    chk_log(1, 0, 1);
    chk_log(1, 1, 4);

    // 3: cnt.ready low, lengths 2,2,2 -> stall on second boundary, then release
    cnt_ready[1] = 1'b0;
    fork
      txn(1, 2, 2, 2, 8'h80);
      begin
        idle(8);
        @(negedge clk);
        chk("t3_stalled_ready", 1, din_ready[1], 0);
        chk("t3_report_held", 1, cnt_valid[1], 1);
        @(posedge clk);
        #1;
        cnt_ready[1] = 1'b1;
      end
    join
    idle(4);
    chk_log(1, 2, 2);
    chk_log(1, 3, 2);
    chk("t3_reports", 1, lg_n[1], 4);

    // 4: dout.ready toggling, lengths 5,3 -> report 5
    done = 1'b0;
    fork
      begin
        txn(0, 5, 3, 0, 8'hA0);
        done = 1'b1;
      end
      while (!done) begin
        @(posedge clk);
        #1;
        dout_ready[0] = ~dout_ready[0];
      end
    join
    dout_ready[0] = 1'b1;
    idle(4);
    chk_log(0, 1, 5);

    // 5: CNT_W=3, first segment of 10 saturates at 7; next transaction restarts
    txn(2, 10, 4, 0, 8'h20);
    txn(2, 3, 2, 0, 8'h60);
    idle(4);
    chk_log(2, 0, 7);
    chk_log(2, 1, 3);

    // 6: reset with segment 1 in progress and a report pending
    cnt_ready[0] = 1'b0;
    ec[0][ec_w[0]] = 3;
    ec_w[0] = ec_w[0] + 1;
    put(0, 9'h0C1, 1'b0);
    put(0, 9'h0C2, 1'b0);
    put(0, 9'h1C3, 1'b0);
    put(0, 9'h0D0, 1'b0);
    put(0, 9'h0D1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_cnt_valid", 0, cnt_valid[0], 0);
    chk("t6_dout_valid", 0, dout_valid[0], 0);
    cnt_ready[0] = 1'b1;
    idle(1);
    txn(0, 2, 1, 0, 8'hE0);
    idle(4);
    chk_log(0, 2, 2);
    chk("t6_reports", 0, lg_n[0], 3);
    chk("t6_outputs_drained", 0, eo_w[0] - eo_r[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
